// File: rtl/bit_pair_packer.sv
// Packs PAIRS enable-qualified bit pairs into one 2*PAIRS-bit word behind a one-entry
// valid/ready output register. Define PACKER_PARITY_EN to add a registered parityOut.
module bit_pair_packer #(
  parameter int PAIRS     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = 2 * PAIRS,
  localparam int CW       = $clog2(PAIRS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          bitEnable,
  input  logic          bitIn1,
  input  logic          bitIn2,
  input  logic          clear,
  input  logic          wordReady,
  output logic [W-1:0]  wordOut,
  output logic          wordValid,
  output logic [CW-1:0] pairCount,
  output logic          overflow
`ifdef PACKER_PARITY_EN
  ,
  output logic          parityOut
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] sh, input logic b1,
                                            input logic b2);
    if (MSB_FIRST) return {sh[W-3:0], b1, b2};
    else           return {b1, b2, sh[W-1:2]};
  endfunction

  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_pair;
  logic          complete;
  state_t        state_q;
  logic [W-1:0]  word_q;
  logic          ovf_q;
`ifdef PACKER_PARITY_EN
  logic          par_q;
`endif

  always_comb begin
    sh_d      = shift_in(sh_q, bitIn1, bitIn2);
    last_pair = (cnt_q == CW'(PAIRS - 1));
    cnt_d     = last_pair ? '0 : cnt_q + CW'(1);
    // sh_d already includes the completing pair, so it is the word handed to the output side
    complete  = bitEnable & ~clear & last_pair;
  end

  // Fill stage: shift register and pair counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (bitEnable) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  // Output stage: one-entry word register with sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      word_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef PACKER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (clear) begin
      state_q <= EMPTY;
      word_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef PACKER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (complete) begin
            state_q <= FULL;
            word_q  <= sh_d;
`ifdef PACKER_PARITY_EN
            par_q   <= ^sh_d;
`endif
          end
        end
        FULL: begin
          if (wordReady) begin
            if (complete) begin
              word_q <= sh_d;
`ifdef PACKER_PARITY_EN
              par_q  <= ^sh_d;
`endif
            end else begin
              state_q <= EMPTY;
            end
          end else if (complete) begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign wordOut   = word_q;
  assign wordValid = (state_q == FULL);
  assign pairCount = cnt_q;
  assign overflow  = ovf_q;
`ifdef PACKER_PARITY_EN
  assign parityOut = par_q;
`endif

endmodule

// File: tb/tb_bit_pair_packer.sv
// Directed bench for bit_pair_packer: one MSB-first and one LSB-first instance share stimulus.
module tb_bit_pair_packer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bitEnable, bitIn1, bitIn2, clear, wordReady;
  logic [7:0] wordOut, lsb_word;
  logic       wordValid, lsb_valid;
  logic [1:0] pairCount, lsb_cnt;
  logic       overflow, lsb_ovf;
`ifdef PACKER_PARITY_EN
  logic       parityOut, lsb_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bit_pair_packer #(.PAIRS(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bitEnable(bitEnable), .bitIn1(bitIn1), .bitIn2(bitIn2),
    .clear(clear), .wordReady(wordReady), .wordOut(wordOut), .wordValid(wordValid),
    .pairCount(pairCount), .overflow(overflow)
`ifdef PACKER_PARITY_EN
    , .parityOut(parityOut)
`endif
  );

  bit_pair_packer #(.PAIRS(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .bitEnable(bitEnable), .bitIn1(bitIn1), .bitIn2(bitIn2),
    .clear(clear), .wordReady(wordReady), .wordOut(lsb_word), .wordValid(lsb_valid),
    .pairCount(lsb_cnt), .overflow(lsb_ovf)
`ifdef PACKER_PARITY_EN
    , .parityOut(lsb_par)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs applied on the falling edge, consumed on the next rising edge, back at falling edge.
  task automatic step(input logic en, input logic b1, input logic b2, input logic rdy,
                      input logic clr);
    bitEnable = en; bitIn1 = b1; bitIn2 = b2; wordReady = rdy; clear = clr;
    @(negedge clk);
    bitEnable = 1'b0; wordReady = 1'b0; clear = 1'b0;
  endtask

  task automatic pair(input logic [1:0] p, input logic rdy);
    step(1'b1, p[1], p[0], rdy, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'bx, 1'bx, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; bitEnable = 1'b0; bitIn1 = 1'b0; bitIn2 = 1'b0;
    clear = 1'b0; wordReady = 1'b0;
    #2;
    check("rst_word", 32'(wordOut), 32'h0);
    check("rst_valid", 32'(wordValid), 32'h0);
    check("rst_cnt", 32'(pairCount), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic packing, both orders
    pair(2'b11, 1'b0); pair(2'b00, 1'b0); pair(2'b10, 1'b0);
    check("t2_cnt3", 32'(pairCount), 32'd3);
    check("t2_valid_early", 32'(wordValid), 32'h0);
    pair(2'b01, 1'b0);
    check("t2_valid", 32'(wordValid), 32'h1);
    check("t2_word_msb", 32'(wordOut), 32'hC9);
    check("t2_word_lsb", 32'(lsb_word), 32'h63);
    check("t2_valid_lsb", 32'(lsb_valid), 32'h1);
    check("t2_cnt", 32'(pairCount), 32'h0);
    check("t2_ovf", 32'(overflow), 32'h0);
    gap(); gap();
    check("t2_hold_word", 32'(wordOut), 32'hC9);
    check("t2_hold_valid", 32'(wordValid), 32'h1);

    // Overflow while pending
    pair(2'b11, 1'b0); pair(2'b11, 1'b0); pair(2'b11, 1'b0);
    check("t3_no_ovf_yet", 32'(overflow), 32'h0);
    pair(2'b11, 1'b0);
    check("t3_ovf", 32'(overflow), 32'h1);
    check("t3_ovf_lsb", 32'(lsb_ovf), 32'h1);
    check("t3_word", 32'(wordOut), 32'hC9);
    check("t3_valid", 32'(wordValid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_pop_valid", 32'(wordValid), 32'h0);
    check("t3_ovf_sticky", 32'(overflow), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_ready_empty", 32'(wordValid), 32'h0);

    // Back-to-back accept with no bubble
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_clr_ovf", 32'(overflow), 32'h0);
    check("t4_clr_valid", 32'(wordValid), 32'h0);
    pair(2'b11, 1'b0); pair(2'b00, 1'b0); pair(2'b10, 1'b0); pair(2'b01, 1'b0);
    check("t4_w1", 32'(wordOut), 32'hC9);
    pair(2'b11, 1'b0); pair(2'b11, 1'b0); pair(2'b00, 1'b0);
    pair(2'b00, 1'b1);
    check("t4_valid", 32'(wordValid), 32'h1);
    check("t4_word", 32'(wordOut), 32'hF0);
    check("t4_word_lsb", 32'(lsb_word), 32'h0F);
    check("t4_ovf", 32'(overflow), 32'h0);

    // Clear priority and X during gaps
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pair(2'b11, 1'b0); pair(2'b11, 1'b0);
    check("t5_cnt2", 32'(pairCount), 32'd2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t5_clr_cnt", 32'(pairCount), 32'h0);
    check("t5_clr_cnt_lsb", 32'(lsb_cnt), 32'h0);
    check("t5_clr_valid", 32'(wordValid), 32'h0);
    pair(2'b10, 1'b0); gap(); gap();
    check("t5_gap_cnt", 32'(pairCount), 32'd1);
    pair(2'b10, 1'b0); gap(); pair(2'b10, 1'b0); gap(); gap(); gap();
    check("t5_gap_valid", 32'(wordValid), 32'h0);
    pair(2'b10, 1'b0); gap();
    check("t5_word", 32'(wordOut), 32'hAA);
    check("t5_valid", 32'(wordValid), 32'h1);
    check("t5_word_lsb", 32'(lsb_word), 32'hAA);

`ifdef PACKER_PARITY_EN
    check("t6_par_aa", 32'(parityOut), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pair(2'b11, 1'b0); pair(2'b00, 1'b0); pair(2'b10, 1'b0); pair(2'b00, 1'b0);
    check("t6_word", 32'(wordOut), 32'hC8);
    check("t6_par1", 32'(parityOut), 32'h1);
    check("t6_par1_lsb", 32'(lsb_par), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pair(2'b11, 1'b0); pair(2'b00, 1'b0); pair(2'b10, 1'b0); pair(2'b01, 1'b0);
    check("t6_word2", 32'(wordOut), 32'hC9);
    check("t6_par0", 32'(parityOut), 32'h0);
    pair(2'b11, 1'b0); pair(2'b00, 1'b0); pair(2'b10, 1'b0); pair(2'b00, 1'b1);
    check("t6_par_reload", 32'(parityOut), 32'h1);
`endif

    // Asynchronous reset mid-fill with a word pending and overflow set
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pair(2'b11, 1'b0); pair(2'b00, 1'b0); pair(2'b10, 1'b0); pair(2'b01, 1'b0);
    pair(2'b11, 1'b0); pair(2'b11, 1'b0); pair(2'b11, 1'b0); pair(2'b11, 1'b0);
    pair(2'b01, 1'b0); pair(2'b01, 1'b0);
    check("t1_pre_cnt", 32'(pairCount), 32'd2);
    check("t1_pre_ovf", 32'(overflow), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("t1_word", 32'(wordOut), 32'h0);
    check("t1_valid", 32'(wordValid), 32'h0);
    check("t1_cnt", 32'(pairCount), 32'h0);
    check("t1_ovf", 32'(overflow), 32'h0);
    check("t1_word_lsb", 32'(lsb_word), 32'h0);
    check("t1_valid_lsb", 32'(lsb_valid), 32'h0);
`ifdef PACKER_PARITY_EN
    check("t1_par", 32'(parityOut), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
